// File: rtl/uart_slip_decode_if.sv
// Byte-stream bundle around the SLIP decoder: raw UART bytes in, framed payload out.
// Latency: none (wires only).
// Backpressure: valid/ready on both streams; the decoder side uses modport slave.
interface uart_slip_decode_if;
    // raw byte stream from uart_rx
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    // decoded packet stream toward the packet consumer
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;
    logic       m_axis_tuser;

    // the decoder: sinks the raw stream, sources the packet stream
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    // the environment around the decoder: uart_rx upstream plus the packet sink
    modport master (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/uart_slip_decode.sv
// SLIP (RFC 1055) decoder: raw bytes -> packet stream with tlast and tuser (bad frame).
// Latency: payload byte N leaves the cycle after byte N+1 or the closing END is accepted.
// Backpressure: s_axis_tready = !rst & (!m_axis_tvalid | m_axis_tready); 1 B/clk sustained.
module uart_slip_decode #(
    parameter int MAX_FRAME_LEN = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_slip_decode_if.slave    bus,
    output logic                 bad_escape,
    output logic                 overlength
);
    localparam int LW = $clog2(MAX_FRAME_LEN + 1);
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_FRAME_LEN);

    localparam logic [7:0] END_B   = 8'hC0;
    localparam logic [7:0] ESC_B   = 8'hDB;
    localparam logic [7:0] ESC_END = 8'hDC;
    localparam logic [7:0] ESC_ESC = 8'hDD;

    // decoder states; all transitions happen only on an accepted input byte
    localparam logic [1:0] ST_DATA = 2'd0;   // plain payload
    localparam logic [1:0] ST_ESC  = 2'd1;   // previous byte was ESC
    localparam logic [1:0] ST_DROP = 2'd2;   // frame already bad, skip to END

    logic [1:0]    state, state_nxt;
    logic          hold_vld, hold_vld_nxt;
    logic [7:0]    hold_dat, hold_dat_nxt;
    logic [LW-1:0] len, len_nxt;
    logic          err, err_nxt;

    logic [7:0]    m_dat;
    logic          m_vld;
    logic          m_last;
    logic          m_user;

    logic          in_acc;
    logic          out_acc;
    logic          term;
    logic          store;
    logic [7:0]    store_dat;
    logic          emit;
    logic          emit_last;
    logic          emit_user;
    logic          bad_esc_nxt;
    logic          ovl_nxt;

    // single output stage: a new byte may enter whenever the stage is empty or draining
    assign bus.s_axis_tready = !rst && (!m_vld || bus.m_axis_tready);
    assign in_acc            = bus.s_axis_tvalid && bus.s_axis_tready;
    assign out_acc           = m_vld && bus.m_axis_tready;

    assign bus.m_axis_tdata  = m_dat;
    assign bus.m_axis_tvalid = m_vld;
    assign bus.m_axis_tlast  = m_last;
    assign bus.m_axis_tuser  = m_user;

    // decode one accepted byte: classify it, then either terminate the frame or store a byte
    always_comb begin
        state_nxt    = state;
        hold_vld_nxt = hold_vld;
        hold_dat_nxt = hold_dat;
        len_nxt      = len;
        err_nxt      = err;
        term         = 1'b0;
        store        = 1'b0;
        store_dat    = bus.s_axis_tdata;
        emit         = 1'b0;
        emit_last    = 1'b0;
        emit_user    = 1'b0;
        bad_esc_nxt  = 1'b0;
        ovl_nxt      = 1'b0;

        if (in_acc) begin
            case (state)
                ST_DATA: begin
                    if (bus.s_axis_tdata == END_B) begin
                        term = 1'b1;
                    end else if (bus.s_axis_tdata == ESC_B) begin
                        state_nxt = ST_ESC;
                    end else begin
                        store = 1'b1;
                    end
                end
                ST_ESC: begin
                    if (bus.s_axis_tdata == ESC_END) begin
                        store     = 1'b1;
                        store_dat = END_B;
                        state_nxt = ST_DATA;
                    end else if (bus.s_axis_tdata == ESC_ESC) begin
                        store     = 1'b1;
                        store_dat = ESC_B;
                        state_nxt = ST_DATA;
                    end else if (bus.s_axis_tdata == END_B) begin
                        // a dangling ESC still lets the END close the frame, marked bad
                        bad_esc_nxt = 1'b1;
                        err_nxt     = 1'b1;
                        term        = 1'b1;
                    end else begin
                        bad_esc_nxt = 1'b1;
                        err_nxt     = 1'b1;
                        state_nxt   = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (bus.s_axis_tdata == END_B) begin
                        term = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_DATA;
                end
            endcase
        end

        // closing END: release the held byte as the frame's last beat, reset frame context
        if (term) begin
            emit         = hold_vld;
            emit_last    = 1'b1;
            emit_user    = err_nxt || (state == ST_DROP);
            hold_vld_nxt = 1'b0;
            len_nxt      = '0;
            err_nxt      = 1'b0;
            state_nxt    = ST_DATA;
        end

        // payload byte: the previous held byte goes out, the new one is held back
        if (store) begin
            if (len == MAX_LEN) begin
                ovl_nxt   = 1'b1;
                err_nxt   = 1'b1;
                state_nxt = ST_DROP;
            end else begin
                emit         = hold_vld;
                emit_last    = 1'b0;
                emit_user    = 1'b0;
                hold_dat_nxt = store_dat;
                hold_vld_nxt = 1'b1;
                len_nxt      = len + LW'(1);
            end
        end
    end

    // frame context registers; reset drops any partial frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_DATA;
            hold_vld <= 1'b0;
            hold_dat <= 8'h00;
            len      <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_vld <= hold_vld_nxt;
            hold_dat <= hold_dat_nxt;
            len      <= len_nxt;
            err      <= err_nxt;
        end
    end

    // output stage: drains on accept, reloads when the decoder emits a beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_vld  <= 1'b0;
            m_dat  <= 8'h00;
            m_last <= 1'b0;
            m_user <= 1'b0;
        end else begin
            if (out_acc) begin
                m_vld <= 1'b0;
            end
            if (emit) begin
                m_vld  <= 1'b1;
                m_dat  <= hold_dat;
                m_last <= emit_last;
                m_user <= emit_user;
            end
        end
    end

    // error pulses, one cycle each
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_escape <= 1'b0;
            overlength <= 1'b0;
        end else begin
            bad_escape <= bad_esc_nxt;
            overlength <= ovl_nxt;
        end
    end
endmodule

// File: tb/tb_uart_slip_decode.sv
// Scoreboard bench for uart_slip_decode: directed SLIP streams plus random frames.
// Expected beats come from a frame-level reference model and are popped by a monitor.
// Output readiness is either held high or randomised to exercise stalls.
module tb_uart_slip_decode;
    localparam int MAXL = 4;
    localparam logic [7:0] C0 = 8'hC0;
    localparam logic [7:0] DB = 8'hDB;
    localparam logic [7:0] DC = 8'hDC;
    localparam logic [7:0] DD = 8'hDD;

    logic clk = 1'b0;
    logic rst;
    logic bad_escape;
    logic overlength;

    uart_slip_decode_if bus();

    uart_slip_decode #(.MAX_FRAME_LEN(MAXL)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .bad_escape (bad_escape),
        .overlength (overlength)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_bad  = 0;
    int exp_ovl  = 0;
    int bad_seen = 0;
    int ovl_seen = 0;
    int rdy_mode = 0;
    logic [9:0] exp_q[$];   // {tuser, tlast, tdata}
    logic       stall_pend = 1'b0;
    logic [9:0] stall_val;

    // ---------------- reference model (frame level) ----------------
    task automatic model_frame(input logic [7:0] seg[$]);
        logic [7:0] pay[$];
        bit bad;
        int i;
        bad = 0;
        i = 0;
        while (i < seg.size()) begin
            logic [7:0] d;
            if (seg[i] == DB) begin
                if (i + 1 >= seg.size() || (seg[i+1] != DC && seg[i+1] != DD)) begin
                    exp_bad++;
                    bad = 1;
                    break;
                end
                d = (seg[i+1] == DC) ? C0 : DB;
                i += 2;
            end else begin
                d = seg[i];
                i += 1;
            end
            if (pay.size() == MAXL) begin
                exp_ovl++;
                bad = 1;
                break;
            end
            pay.push_back(d);
        end
        for (int k = 0; k < pay.size(); k++) begin
            logic lst;
            lst = (k == pay.size() - 1);
            exp_q.push_back({lst && bad, lst, pay[k]});
        end
    endtask

    task automatic model_stream(input logic [7:0] s[$]);
        logic [7:0] seg[$];
        foreach (s[i]) begin
            if (s[i] == C0) begin
                model_frame(seg);
                seg.delete();
            end else begin
                seg.push_back(s[i]);
            end
        end
    endtask

    // ---------------- drivers ----------------
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) bus.m_axis_tready = 1'b1;
        else               bus.m_axis_tready = 1'($urandom_range(0, 1));
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        bit done;
        n = 0;
        done = 0;
        bus.s_axis_tdata  = b;
        bus.s_axis_tvalid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = bus.s_axis_tready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout byte=%02h tready=%0b required=1", b, bus.s_axis_tready);
                done = 1;
            end
        end
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit gaps);
        model_stream(s);
        foreach (s[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_byte(s[i]);
        end
    endtask

    task automatic finish_test(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_beats_missing got_pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (bus.m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle tvalid=%0b required=0", name, bus.m_axis_tvalid);
        end
        checks++;
        if (bad_seen != exp_bad) begin
            failures++;
            $display("FAIL %s_bad_escape pulses=%0d required=%0d", name, bad_seen, exp_bad);
            bad_seen = exp_bad;
        end
        checks++;
        if (ovl_seen != exp_ovl) begin
            failures++;
            $display("FAIL %s_overlength pulses=%0d required=%0d", name, ovl_seen, exp_ovl);
            ovl_seen = exp_ovl;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 1'b0;
            checks++;
            if (bus.m_axis_tvalid !== 1'b0 || bus.s_axis_tready !== 1'b0 ||
                bus.m_axis_tlast !== 1'b0 || bus.m_axis_tuser !== 1'b0 ||
                bad_escape !== 1'b0 || overlength !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs vld=%0b rdy=%0b last=%0b user=%0b be=%0b ov=%0b required all 0",
                         bus.m_axis_tvalid, bus.s_axis_tready, bus.m_axis_tlast,
                         bus.m_axis_tuser, bad_escape, overlength);
            end
        end else begin
            logic [9:0] got;
            got = {bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata};
            if (bad_escape === 1'b1) bad_seen++;
            if (overlength === 1'b1) ovl_seen++;
            if (stall_pend) begin
                checks++;
                if (bus.m_axis_tvalid !== 1'b1 || got !== stall_val) begin
                    failures++;
                    $display("FAIL stall_stable got vld=%0b beat=%03h required vld=1 beat=%03h",
                             bus.m_axis_tvalid, got, stall_val);
                end
            end
            if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
                stall_pend = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat got user=%0b last=%0b data=%02h required none",
                             got[9], got[8], got[7:0]);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL beat got user=%0b last=%0b data=%02h required user=%0b last=%0b data=%02h",
                                 got[9], got[8], got[7:0], e[9], e[8], e[7:0]);
                    end
                end
            end else if (bus.m_axis_tvalid === 1'b1) begin
                stall_pend = 1'b1;
                stall_val  = got;
            end else begin
                stall_pend = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [7:0] rand_byte();
        logic [7:0] pick[4];
        pick[0] = DB;
        pick[1] = DC;
        pick[2] = DD;
        pick[3] = C0;
        if ($urandom_range(0, 3) == 0) return pick[$urandom_range(0, 2)];
        if ($urandom_range(0, 19) == 0) return pick[3];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s[$];
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = 8'h00;
        bus.m_axis_tready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        s = '{C0, 8'h11, 8'h22, 8'h33, C0};
        send_stream(s, 0);
        finish_test("t1_basic");

        s = '{8'h01, DB, DC, DB, DD, 8'h02, C0};
        send_stream(s, 0);
        finish_test("t2_escape");

        s = '{8'h41, DB, 8'h55, 8'h66, C0};
        send_stream(s, 0);
        finish_test("t3_bad_escape");

        s = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, C0};
        send_stream(s, 0);
        finish_test("t4_overlength");

        s = '{C0, C0, C0};
        send_stream(s, 0);
        s = '{8'h7E, C0};
        send_stream(s, 0);
        finish_test("t5_empty");

        s = '{DB, 8'h01, C0, DB, C0, 8'hAA, DB, C0};
        send_stream(s, 0);
        finish_test("t5_dangling_esc");

        rdy_mode = 1;
        for (int r = 0; r < 6; r++) begin
            s = '{C0, 8'h11, 8'h22, 8'h33, C0};
            send_stream(s, 1);
        end
        finish_test("t5_stall");

        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        s = '{8'h33, C0};
        send_stream(s, 0);
        finish_test("t6_reset");

        rdy_mode = 1;
        for (int f = 0; f < 60; f++) begin
            int n;
            s.delete();
            n = $urandom_range(0, 7);
            for (int k = 0; k < n; k++) s.push_back(rand_byte());
            s.push_back(C0);
            send_stream(s, 1);
        end
        finish_test("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
